bram_to_dma: RTL and testbench
==============================

BRAM_TO_DMA -- requirements
Module: bram_to_dma

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 512, giving the maximum number of 32-bit words streamed per transfer.
REQ-002 The block SHALL have parameter LEN_W, default 10, giving the width of the len input.
REQ-003 clk  input  1  single system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a transfer; accepted only in IDLE.
REQ-006 len  input  LEN_W  number of words to stream, sampled when start is accepted.
REQ-007 busy  output  1  high from the cycle after start is accepted until the last beat handshakes.
REQ-008 done  output  1  one-cycle pulse when a transfer completes.
REQ-009 clka  output  1  equals clk.
REQ-010 rsta  output  1  equals rst.
REQ-011 ena  output  1  BRAM read enable.
REQ-012 addra  output  32  BRAM byte address.
REQ-013 dina  output  32  tied to 0.
REQ-014 wea  output  4  tied to 4'h0, because the port is read-only.
REQ-015 douta  input  32  BRAM read data.
REQ-016 m_axis_tdata  output  32  stream data.
REQ-017 m_axis_tvalid  output  1  stream valid.
REQ-018 m_axis_tready  input  1  downstream ready.
REQ-019 m_axis_tlast  output  1  marks the final word of a transfer.

Function
REQ-020 The state machine SHALL have three states: IDLE, READ and DRAIN.
- IDLE -> READ on start with effective length nonzero.
- READ -> DRAIN once all reads are issued.
- DRAIN -> IDLE on the handshake of the tlast beat.
REQ-021 The effective length SHALL be computed as follows:
- len greater than DEPTH_WORDS is clamped to DEPTH_WORDS.
- len==0 stays in IDLE, pulses done one cycle after start, and emits no beats.
REQ-022 Reads SHALL start at addra=0 and increment addra by 4 per issued read (ena=1); addra returns to 0 in IDLE.
REQ-023 Read latency SHALL be 1 cycle: douta is valid the cycle after ena=1.
REQ-024 Returned words SHALL enter a 2-entry output buffer, and a read SHALL issue only when buffer occupancy plus in-flight reads is less than 2, so no word is ever lost.
REQ-025 m_axis_tvalid SHALL be registered and high whenever the buffer is non-empty; a beat transfers on tvalid && tready.
REQ-026 While tvalid=1 and tready=0, tdata, tlast and tvalid SHALL hold stable.
REQ-027 m_axis_tlast SHALL be 1 only on word index (effective length - 1).
REQ-028 Latency SHALL be: start accepted at cycle N -> first ena at N+1 -> first tvalid at N+2.
REQ-029 With tready held at 1, throughput SHALL be one word per clk.
REQ-030 done SHALL pulse in the cycle after the tlast handshake; busy falls in that same cycle.
REQ-031 start asserted while busy SHALL be ignored.
REQ-032 start arriving in the cycle done pulses SHALL be accepted.

Reset
REQ-033 On rst=1 the block SHALL asynchronously go to IDLE and clear the buffer and in-flight count.
- Outputs clear: addra=0, ena=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0.
REQ-034 Reset mid-transfer SHALL abort the transfer with no tlast and no done; the next start begins again at address 0.

Configuration
REQ-035 The macro BRAM_TO_DMA_BRAM_OREG_EN SHALL select BRAM read latency.
- Defined: BRAM output register is assumed, read latency is 2 cycles, the buffer is 3 entries, the issue limit is occupancy plus in-flight < 3, and first tvalid is at N+3.
- Undefined: the 1-cycle behaviour of REQ-023 to REQ-028 applies.
- Throughput with tready=1 SHALL be one word per clk in both builds.

Verification
REQ-036 len=4, tready=1, BRAM[i]=0xA000_0000+i -> addra 0,4,8,12; beats A0000000..A0000003 on consecutive cycles; tlast on the 4th beat; done one cycle later.
REQ-037 len=8, tready toggling 1,0,1,0 -> exactly 8 beats in order; data stable during stalls; ena never raised with the buffer plus in-flight count full.
REQ-038 len=0 -> no tvalid; done pulses the cycle after start; busy stays 0.
REQ-039 len=1000 (DEPTH_WORDS=512) -> 512 beats; last addra=2044; tlast on beat 512.
REQ-040 rst pulsed after 3 of 6 beats, then start len=2 -> no tlast or done from the aborted transfer; the new transfer reads addra 0,4.
REQ-041 Repeat REQ-036 and REQ-037 with BRAM_TO_DMA_BRAM_OREG_EN defined -> identical beat sequence; first tvalid at N+3.

Source files
------------

// File: rtl/bram_to_dma.sv
// Streams a block of 32-bit words from a BRAM read port onto an AXI-Stream master.
// Define BRAM_TO_DMA_BRAM_OREG_EN when the BRAM output register is enabled (2-cycle read latency).
module bram_to_dma #(
    parameter int DEPTH_WORDS = 512,
    parameter int LEN_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             clka,
    output logic             rsta,
    output logic             ena,
    output logic [31:0]      addra,
    output logic [31:0]      dina,
    output logic [3:0]       wea,
    input  logic [31:0]      douta,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

`ifdef BRAM_TO_DMA_BRAM_OREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif
    // One buffer slot per cycle of read latency plus one keeps reads flowing at full rate.
    localparam int BUF_N = RD_LAT + 1;
    localparam int CNT_W = $clog2(DEPTH_WORDS + 1);
    localparam int OCC_W = $clog2(BUF_N + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t           state_reg;
    logic             ena_reg;
    logic             ena_last_reg;
    logic [31:0]      addra_reg;
    logic [31:0]      next_addr_reg;
    logic [CNT_W-1:0] rd_left_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             tvalid_reg;

    logic             pend_valid_reg [RD_LAT];
    logic             pend_last_reg  [RD_LAT];
    logic [31:0]      q_reg  [BUF_N];
    logic             ql_reg [BUF_N];
    logic [OCC_W-1:0] occ_reg;

    logic             pend_valid_next [RD_LAT];
    logic             pend_last_next  [RD_LAT];
    logic [31:0]      q_next  [BUF_N];
    logic             ql_next [BUF_N];
    logic [OCC_W-1:0] occ_mid;
    logic [OCC_W-1:0] occ_next;
    int               inflight_next;
    logic             tvalid_next;
    logic             can_issue;

    logic             landing;
    logic             landing_last;
    logic             head_last;
    logic             fire;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] eff_len;

    assign clka = clk;
    assign rsta = rst;
    assign dina = 32'h0;
    assign wea  = 4'h0;

    assign ena           = ena_reg;
    assign addra         = addra_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign m_axis_tvalid = tvalid_reg;

    // The word arriving on douta this cycle is presented directly when nothing older is queued.
    assign landing      = pend_valid_reg[RD_LAT-1];
    assign landing_last = pend_last_reg[RD_LAT-1];
    assign head_last    = (occ_reg != '0) ? ql_reg[0] : (landing & landing_last);
    assign m_axis_tdata = (occ_reg != '0) ? q_reg[0] : (landing ? douta : 32'h0);
    assign m_axis_tlast = head_last;

    assign fire = tvalid_reg & m_axis_tready;
    assign pop  = fire & (occ_reg != '0);
    assign push = landing & ~(fire & (occ_reg == '0));

    always_comb begin
        if (32'(len) > 32'(DEPTH_WORDS)) begin
            eff_len = CNT_W'(DEPTH_WORDS);
        end else begin
            eff_len = CNT_W'(len);
        end
    end

    always_comb begin
        for (int i = 0; i < BUF_N; i++) begin
            q_next[i]  = q_reg[i];
            ql_next[i] = ql_reg[i];
        end
        occ_mid = occ_reg;
        if (pop) begin
            for (int i = 0; i < BUF_N - 1; i++) begin
                q_next[i]  = q_reg[i+1];
                ql_next[i] = ql_reg[i+1];
            end
            occ_mid = occ_reg - 1'b1;
        end
        occ_next = occ_mid;
        if (push) begin
            for (int i = 0; i < BUF_N; i++) begin
                if (OCC_W'(i) == occ_mid) begin
                    q_next[i]  = douta;
                    ql_next[i] = landing_last;
                end
            end
            occ_next = occ_mid + 1'b1;
        end

        pend_valid_next[0] = ena_reg;
        pend_last_next[0]  = ena_last_reg;
        for (int i = 1; i < RD_LAT; i++) begin
            pend_valid_next[i] = pend_valid_reg[i-1];
            pend_last_next[i]  = pend_last_reg[i-1];
        end
        inflight_next = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_next = inflight_next + int'(pend_valid_next[i]);
        end

        // Issue a read only when every word already requested still has a slot to land in.
        can_issue   = (int'(occ_next) + inflight_next) < BUF_N;
        tvalid_next = (occ_next != '0) | pend_valid_next[RD_LAT-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg <= '0;
            for (int i = 0; i < BUF_N; i++) begin
                q_reg[i]  <= 32'h0;
                ql_reg[i] <= 1'b0;
            end
            for (int i = 0; i < RD_LAT; i++) begin
                pend_valid_reg[i] <= 1'b0;
                pend_last_reg[i]  <= 1'b0;
            end
        end else begin
            occ_reg <= occ_next;
            for (int i = 0; i < BUF_N; i++) begin
                q_reg[i]  <= q_next[i];
                ql_reg[i] <= ql_next[i];
            end
            for (int i = 0; i < RD_LAT; i++) begin
                pend_valid_reg[i] <= pend_valid_next[i];
                pend_last_reg[i]  <= pend_last_next[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ena_reg       <= 1'b0;
            ena_last_reg  <= 1'b0;
            addra_reg     <= 32'h0;
            next_addr_reg <= 32'h0;
            rd_left_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            tvalid_reg    <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            ena_reg      <= 1'b0;
            ena_last_reg <= 1'b0;
            tvalid_reg   <= tvalid_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (eff_len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg     <= READ;
                            busy_reg      <= 1'b1;
                            ena_reg       <= 1'b1;
                            ena_last_reg  <= (eff_len == CNT_W'(1));
                            addra_reg     <= 32'h0;
                            next_addr_reg <= 32'h4;
                            rd_left_reg   <= eff_len - 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_left_reg == '0) begin
                        state_reg <= DRAIN;
                    end else if (can_issue) begin
                        ena_reg       <= 1'b1;
                        ena_last_reg  <= (rd_left_reg == CNT_W'(1));
                        addra_reg     <= next_addr_reg;
                        next_addr_reg <= next_addr_reg + 32'h4;
                        rd_left_reg   <= rd_left_reg - 1'b1;
                        if (rd_left_reg == CNT_W'(1)) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fire && head_last) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        addra_reg <= 32'h0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_to_dma.sv
// Table-driven bench for bram_to_dma with a behavioural BRAM (1 or 2 cycle read latency).
module tb_bram_to_dma;

`ifdef BRAM_TO_DMA_BRAM_OREG_EN
    localparam int EXP_LAT = 3;
    localparam int BUF_N   = 3;
`else
    localparam int EXP_LAT = 2;
    localparam int BUF_N   = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  len;
    logic        busy, done, clka, rsta, ena;
    logic [31:0] addra, dina, douta, tdata;
    logic [3:0]  wea;
    logic        tvalid, tready, tlast;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_to_dma #(.DEPTH_WORDS(512), .LEN_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .busy(busy), .done(done), .clka(clka), .rsta(rsta),
        .ena(ena), .addra(addra), .dina(dina), .wea(wea), .douta(douta),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast)
    );

    logic [31:0] mem [0:511];
    logic [31:0] rd_q;
    always @(posedge clka) begin
        if (ena) rd_q <= mem[addra[10:2]];
    end
`ifdef BRAM_TO_DMA_BRAM_OREG_EN
    logic [31:0] oreg_q;
    always @(posedge clka) oreg_q <= rd_q;
    assign douta = oreg_q;
`else
    assign douta = rd_q;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int len;
        int stall;          // 0: ready always, 1: toggle 1,0,..., 2: low every third cycle
        int restart;        // cycle at which a start is re-pulsed while busy (-1 none)
        int b2b;            // start is raised in the done cycle of the previous transfer
        int exp_beats;
        int exp_last_addr;
    } vec_t;

    task automatic run_vec(input int id, input vec_t v);
        int c, issued, beats, first_valid, tlast_cycle;
        logic [31:0] last_addr, prev_data;
        logic prev_stall, prev_last, tr, exp_busy, exp_done;
        bit fin;
        c = 0; issued = 0; beats = 0; first_valid = -1; tlast_cycle = -1;
        last_addr = 32'h0; prev_data = 32'h0; prev_stall = 1'b0; prev_last = 1'b0; fin = 1'b0;
        if (v.b2b == 0) @(negedge clk);
        start = 1'b1;
        len = v.len[9:0];
        tready = 1'b1;
        while (!fin && c < 3000) begin
            @(negedge clk);
            c++;
            start = (c == v.restart);
            if (c == v.restart) len = 10'd9;
            case (v.stall)
                0: tr = 1'b1;
                1: tr = c[0];
                default: tr = ((c % 3) != 0);
            endcase
            tready = tr;
            if (prev_stall) begin
                check("hold_tdata", tdata, prev_data);
                check("hold_tlast", {31'b0, tlast}, {31'b0, prev_last});
                check("hold_tvalid", {31'b0, tvalid}, 32'd1);
            end
            if (ena) begin
                check("addra", addra, 32'(issued * 4));
                check("issue_limit", {31'b0, (issued - beats) < BUF_N}, 32'd1);
                issued++;
                last_addr = addra;
            end
            if (tvalid && first_valid < 0) first_valid = c;
            if (tvalid && tr) begin
                check("tdata", tdata, 32'hA000_0000 + 32'(beats));
                check("tlast", {31'b0, tlast}, {31'b0, beats == v.exp_beats - 1});
                if (v.stall == 0) check("throughput", 32'(c), 32'(first_valid + beats));
                beats++;
                if (tlast) tlast_cycle = c;
            end
            exp_busy = (v.exp_beats > 0) && (tlast_cycle < 0 || c <= tlast_cycle);
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            exp_done = (v.exp_beats == 0) ? (c == 1) : (tlast_cycle >= 0 && c == tlast_cycle + 1);
            check("done", {31'b0, done}, {31'b0, exp_done});
            prev_stall = tvalid && !tr;
            prev_data  = tdata;
            prev_last  = tlast;
            fin = (v.exp_beats == 0) ? (c >= 2) : (tlast_cycle >= 0 && c == tlast_cycle + 1);
        end
        start = 1'b0;
        check("timeout", {31'b0, fin}, 32'd1);
        check("beat_count", 32'(beats), 32'(v.exp_beats));
        check("read_count", 32'(issued), 32'(v.exp_beats));
        check("first_tvalid", 32'(first_valid), (v.exp_beats > 0) ? 32'(EXP_LAT) : 32'hFFFF_FFFF);
        if (v.exp_beats > 0) check("last_addra", last_addr, 32'(v.exp_last_addr));
        $display("vec %0d len=%0d stall=%0d beats=%0d first_tvalid=%0d tlast_cycle=%0d",
                 id, v.len, v.stall, beats, first_valid, tlast_cycle);
    endtask

    vec_t vecs [7];

    initial begin
        int c, beats;
        for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 + 32'(i);
        vecs[0] = '{len: 4,    stall: 0, restart: -1, b2b: 0, exp_beats: 4,   exp_last_addr: 12};
        vecs[1] = '{len: 8,    stall: 1, restart: -1, b2b: 0, exp_beats: 8,   exp_last_addr: 28};
        vecs[2] = '{len: 0,    stall: 0, restart: -1, b2b: 0, exp_beats: 0,   exp_last_addr: 0};
        vecs[3] = '{len: 1,    stall: 0, restart: -1, b2b: 0, exp_beats: 1,   exp_last_addr: 0};
        vecs[4] = '{len: 3,    stall: 2, restart: -1, b2b: 1, exp_beats: 3,   exp_last_addr: 8};
        vecs[5] = '{len: 5,    stall: 0, restart: 3,  b2b: 0, exp_beats: 5,   exp_last_addr: 16};
        vecs[6] = '{len: 1000, stall: 0, restart: -1, b2b: 0, exp_beats: 512, exp_last_addr: 2044};

        rst = 1'b1; start = 1'b0; len = 10'd0; tready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tvalid", {31'b0, tvalid}, 32'd0);
        check("rst_tlast", {31'b0, tlast}, 32'd0);
        check("rst_tdata", tdata, 32'h0);
        check("rst_ena", {31'b0, ena}, 32'd0);
        check("rst_addra", addra, 32'h0);
        check("rst_busy_done", {30'b0, busy, done}, 32'd0);
        check("rsta", {31'b0, rsta}, 32'd1);
        check("wea_dina", {28'b0, wea} | dina, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Abort a 6-word transfer after three beats with an asynchronous reset.
        @(negedge clk);
        start = 1'b1; len = 10'd6; tready = 1'b1;
        c = 0; beats = 0;
        while (beats < 3 && c < 50) begin
            @(negedge clk);
            start = 1'b0;
            c++;
            if (tvalid && tready) beats++;
        end
        check("abort_setup", 32'(beats), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_tvalid", {31'b0, tvalid}, 32'd0);
        check("abort_ena_addra", {31'b0, ena} | addra, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'b0, done}, 32'd0);
            check("abort_no_tlast", {31'b0, tlast | tvalid}, 32'd0);
        end
        $display("abort: reset after %0d beats", beats);
        run_vec(7, '{len: 2, stall: 0, restart: -1, b2b: 0, exp_beats: 2, exp_last_addr: 4});

        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
